// File: rtl/ec_fpn_addsub_mod.sv
// ec_fpn_addsub_mod -- streaming modular adder / subtractor, (a +/- b) mod P.
//
// Operands arrive least-significant word first, ARITH_BITS per beat, with
// a and b packed side by side. Every word is run through two carry chains:
// the raw sum/difference (s) and the reduced candidate (d). Both are
// buffered, and the choice between them is made once the final carry and
// borrow are known. The selected buffer is then streamed out.
//
// Ports (i_if_* / o_if_* are the flattened if_axi_stream sink / source):
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_if_dat        [ARITH_BITS-1:0] = a word, [2*ARITH_BITS-1:ARITH_BITS] = b word
//   i_if_val/sop/eop/ctl, i_if_rdy   operand stream handshake and framing
//   o_if_dat        result word
//   o_if_val/sop/eop/err/ctl, o_if_rdy  result stream handshake and framing
//
// Optional build macro EC_FPN_ADDSUB_RANGE_CHK_EN: adds per-word a < P and
// b < P compare chains; an out-of-range operand raises err on the eop beat.
module ec_fpn_addsub_mod #(
    parameter int              BITS       = 256,
    parameter int              ARITH_BITS = 64,
    parameter logic [BITS-1:0] P          = '0,
    parameter int              IS_SUB     = 0,
    parameter int              CTL_BITS   = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [2*ARITH_BITS-1:0] i_if_dat,
    input  logic                    i_if_val,
    input  logic                    i_if_sop,
    input  logic                    i_if_eop,
    input  logic [CTL_BITS-1:0]     i_if_ctl,
    output logic                    i_if_rdy,
    output logic [ARITH_BITS-1:0]   o_if_dat,
    output logic                    o_if_val,
    output logic                    o_if_sop,
    output logic                    o_if_eop,
    output logic                    o_if_err,
    output logic [CTL_BITS-1:0]     o_if_ctl,
    input  logic                    o_if_rdy
);

    localparam int DIV = BITS / ARITH_BITS;
    localparam int IW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef logic [IW-1:0]         idx_t;
    typedef logic [ARITH_BITS-1:0] word_t;
    typedef enum logic [0:0] {COLLECT, DRAIN} state_t;

    localparam idx_t LAST = idx_t'(DIV - 1);

    state_t            state_q, state_d;
    idx_t              cnt_q, cnt_d;
    idx_t              last_q, last_d;
    idx_t              rd_q, rd_d;
    logic              c_q, c_d;
    logic              bw_q, bw_d;
    logic              sel_q, sel_d;
    logic              err_q, err_d;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    word_t             s_buf_q [DIV];
    word_t             s_buf_d [DIV];
    word_t             d_buf_q [DIV];
    word_t             d_buf_d [DIV];
`ifdef EC_FPN_ADDSUB_RANGE_CHK_EN
    logic              ra_q, ra_d;
    logic              rb_q, rb_d;
`endif

    idx_t              idx;
    logic              cin, bin;
    word_t             a_w, b_w, p_w, s_w, d_w;
    logic [ARITH_BITS:0] x1, x2;
    logic              c_n, bw_n, use_d, final_beat, rng_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        rd_d      = rd_q;
        c_d       = c_q;
        bw_d      = bw_q;
        sel_d     = sel_q;
        err_d     = err_q;
        ctl_d     = ctl_q;
        s_buf_d   = s_buf_q;
        d_buf_d   = d_buf_q;

        o_if_val  = 1'b0;
        o_if_sop  = 1'b0;
        o_if_eop  = 1'b0;
        o_if_err  = 1'b0;
        o_if_dat  = '0;
        o_if_ctl  = '0;
        i_if_rdy  = (state_q == COLLECT) && !i_rst;

        // A sop beat restarts the operation: word 0, chains cleared.
        idx = i_if_sop ? '0 : cnt_q;
        cin = i_if_sop ? 1'b0 : c_q;
        bin = i_if_sop ? 1'b0 : bw_q;
        a_w = i_if_dat[0 +: ARITH_BITS];
        b_w = i_if_dat[ARITH_BITS +: ARITH_BITS];
        p_w = '0;
        for (int unsigned k = 0; k < DIV; k++) begin
            if (idx == idx_t'(k)) p_w = P[k*ARITH_BITS +: ARITH_BITS];
        end

        if (IS_SUB == 0) begin
            x1    = {1'b0, a_w} + {1'b0, b_w} + {{ARITH_BITS{1'b0}}, cin};
            s_w   = x1[ARITH_BITS-1:0];
            c_n   = x1[ARITH_BITS];
            x2    = {1'b0, s_w} - {1'b0, p_w} - {{ARITH_BITS{1'b0}}, bin};
            d_w   = x2[ARITH_BITS-1:0];
            bw_n  = x2[ARITH_BITS];
            // Carry out means a+b >= 2^BITS > P; no final borrow means s >= P.
            use_d = c_n || !bw_n;
        end else begin
            x1    = {1'b0, a_w} - {1'b0, b_w} - {{ARITH_BITS{1'b0}}, bin};
            s_w   = x1[ARITH_BITS-1:0];
            bw_n  = x1[ARITH_BITS];
            x2    = {1'b0, s_w} + {1'b0, p_w} + {{ARITH_BITS{1'b0}}, cin};
            d_w   = x2[ARITH_BITS-1:0];
            c_n   = x2[ARITH_BITS];
            use_d = bw_n;
        end

`ifdef EC_FPN_ADDSUB_RANGE_CHK_EN
        ra_d    = ra_q;
        rb_d    = rb_q;
        // Borrow-out of x - P, chained per word: set when x < P so far.
        rng_err = !((a_w < p_w) || ((a_w == p_w) && (i_if_sop ? 1'b0 : ra_q))) ||
                  !((b_w < p_w) || ((b_w == p_w) && (i_if_sop ? 1'b0 : rb_q)));
`else
        rng_err = 1'b0;
`endif

        final_beat = i_if_eop || (idx == LAST);

        case (state_q)
            COLLECT: begin
                if (i_if_val && i_if_rdy) begin
                    s_buf_d[idx] = s_w;
                    d_buf_d[idx] = d_w;
                    c_d          = c_n;
                    bw_d         = bw_n;
`ifdef EC_FPN_ADDSUB_RANGE_CHK_EN
                    ra_d = (a_w < p_w) || ((a_w == p_w) && (i_if_sop ? 1'b0 : ra_q));
                    rb_d = (b_w < p_w) || ((b_w == p_w) && (i_if_sop ? 1'b0 : rb_q));
`endif
                    if (i_if_sop) ctl_d = i_if_ctl;
                    if (final_beat) begin
                        state_d = DRAIN;
                        sel_d   = use_d;
                        last_d  = idx;
                        err_d   = (idx != LAST) || rng_err;
                        rd_d    = '0;
                    end else begin
                        cnt_d   = idx + idx_t'(1);
                    end
                end
            end
            DRAIN: begin
                o_if_val = 1'b1;
                o_if_sop = (rd_q == '0);
                o_if_eop = (rd_q == LAST);
                o_if_err = (rd_q == LAST) && err_q;
                o_if_ctl = ctl_q;
                // Words past a short operation were never loaded and read as 0.
                if (rd_q <= last_q) o_if_dat = sel_q ? d_buf_q[rd_q] : s_buf_q[rd_q];
                if (o_if_rdy) begin
                    if (rd_q == LAST) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                        c_d     = 1'b0;
                        bw_d    = 1'b0;
`ifdef EC_FPN_ADDSUB_RANGE_CHK_EN
                        ra_d    = 1'b0;
                        rb_d    = 1'b0;
`endif
                    end else begin
                        rd_d = rd_q + idx_t'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            last_q  <= '0;
            rd_q    <= '0;
            c_q     <= 1'b0;
            bw_q    <= 1'b0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            ctl_q   <= '0;
            for (int unsigned k = 0; k < DIV; k++) begin
                s_buf_q[k] <= '0;
                d_buf_q[k] <= '0;
            end
`ifdef EC_FPN_ADDSUB_RANGE_CHK_EN
            ra_q    <= 1'b0;
            rb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            c_q     <= c_d;
            bw_q    <= bw_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            ctl_q   <= ctl_d;
            s_buf_q <= s_buf_d;
            d_buf_q <= d_buf_d;
`ifdef EC_FPN_ADDSUB_RANGE_CHK_EN
            ra_q    <= ra_d;
            rb_q    <= rb_d;
`endif
        end
    end

endmodule

// File: tb/tb_ec_fpn_addsub_mod.sv
// Bench for ec_fpn_addsub_mod: one ADD and one SUB instance over a 16-bit
// field (P = 0xFFF1, two 8-bit words per operand).
module tb_ec_fpn_addsub_mod;

    localparam int          DIV = 2;
    localparam logic [15:0] P   = 16'hFFF1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_dat;
    logic        in_val, in_sop, in_eop;
    logic [7:0]  in_ctl;
    logic        sel;
    logic        o_rdy;

    logic        add_irdy, add_val, add_sop, add_eop, add_err;
    logic [7:0]  add_dat, add_ctl;
    logic        sub_irdy, sub_val, sub_sop, sub_eop, sub_err;
    logic [7:0]  sub_dat, sub_ctl;

    logic        cur_irdy, cur_val, cur_sop, cur_eop, cur_err;
    logic [7:0]  cur_dat, cur_ctl;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign cur_irdy = sel ? sub_irdy : add_irdy;
    assign cur_val  = sel ? sub_val  : add_val;
    assign cur_sop  = sel ? sub_sop  : add_sop;
    assign cur_eop  = sel ? sub_eop  : add_eop;
    assign cur_err  = sel ? sub_err  : add_err;
    assign cur_dat  = sel ? sub_dat  : add_dat;
    assign cur_ctl  = sel ? sub_ctl  : add_ctl;

    ec_fpn_addsub_mod #(.BITS(16), .ARITH_BITS(8), .P(P), .IS_SUB(0), .CTL_BITS(8)) u_add (
        .i_clk(clk), .i_rst(rst),
        .i_if_dat(in_dat), .i_if_val(in_val && !sel), .i_if_sop(in_sop), .i_if_eop(in_eop),
        .i_if_ctl(in_ctl), .i_if_rdy(add_irdy),
        .o_if_dat(add_dat), .o_if_val(add_val), .o_if_sop(add_sop), .o_if_eop(add_eop),
        .o_if_err(add_err), .o_if_ctl(add_ctl), .o_if_rdy(o_rdy)
    );

    ec_fpn_addsub_mod #(.BITS(16), .ARITH_BITS(8), .P(P), .IS_SUB(1), .CTL_BITS(8)) u_sub (
        .i_clk(clk), .i_rst(rst),
        .i_if_dat(in_dat), .i_if_val(in_val && sel), .i_if_sop(in_sop), .i_if_eop(in_eop),
        .i_if_ctl(in_ctl), .i_if_rdy(sub_irdy),
        .o_if_dat(sub_dat), .o_if_val(sub_val), .o_if_sop(sub_sop), .o_if_eop(sub_eop),
        .o_if_err(sub_err), .o_if_ctl(sub_ctl), .o_if_rdy(o_rdy)
    );

    typedef struct {
        bit          is_sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  ctl;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out waiting on handshake", nm);
    endtask

    // Plain modular arithmetic reference.
    function automatic logic [15:0] ref_model(input bit is_sub, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua, ub, up;
        ua = a; ub = b; up = P;
        return is_sub ? 16'((ua + up - ub) % up) : 16'((ua + ub) % up);
    endfunction

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send(input logic [7:0] aw, input logic [7:0] bw, input logic s, input logic e,
                        input logic [7:0] c);
        int t;
        t = 0;
        in_dat = {bw, aw}; in_val = 1'b1; in_sop = s; in_eop = e; in_ctl = c;
        while (!cur_irdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout("send");
        @(negedge clk);
        in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic op(input bit is_sub, input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
        sel = is_sub;
        send(a[7:0], b[7:0], 1'b1, 1'b0, c);
        send(a[15:8], b[15:8], 1'b0, 1'b1, c);
    endtask

    task automatic recv(input string nm, input logic [15:0] exp, input logic [7:0] c,
                        input logic e, input int stall);
        int         t;
        logic [7:0] ew;
        for (int w = 0; w < DIV; w++) begin
            t  = 0;
            ew = exp[w*8 +: 8];
            while (!cur_val && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) timeout({nm, "_val"});
            if (stall > 0) begin
                o_rdy = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    chk({nm, "_stall_dat"}, 16'(cur_dat), 16'(ew));
                    chk({nm, "_stall_sopeop"}, {14'd0, cur_sop, cur_eop},
                        {14'd0, (w == 0), (w == DIV - 1)});
                    chk({nm, "_stall_irdy"}, 16'(cur_irdy), 16'd0);
                end
                o_rdy = 1'b1;
            end
            chk({nm, "_dat"}, 16'(cur_dat), 16'(ew));
            chk({nm, "_sop"}, 16'(cur_sop), 16'(w == 0));
            chk({nm, "_eop"}, 16'(cur_eop), 16'(w == DIV - 1));
            chk({nm, "_ctl"}, 16'(cur_ctl), 16'(c));
            chk({nm, "_err"}, 16'(cur_err), (w == DIV - 1) ? 16'(e) : 16'd0);
            @(negedge clk);
        end
        chk({nm, "_val_drop"}, 16'(cur_val), 16'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [6];
        logic [15:0] ra, rb, rexp;
        bit          rs;
        logic        exp_rng;

        tbl[0] = '{1'b0, 16'h0005, 16'h0007, 8'h10, 16'h000C};
        tbl[1] = '{1'b0, 16'hFFF0, 16'h0001, 8'h11, 16'h0000};
        tbl[2] = '{1'b0, 16'hFFF0, 16'hFFF0, 8'h12, 16'hFFEF};
        tbl[3] = '{1'b1, 16'h0003, 16'h0005, 8'h13, 16'hFFEF};
        tbl[4] = '{1'b1, 16'h1234, 16'h1234, 8'h14, 16'h0000};
        tbl[5] = '{1'b1, 16'h1234, 16'h0034, 8'h15, 16'h1200};

        rst = 1'b1; in_dat = '0; in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_ctl = '0; sel = 1'b0; o_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_add_val", 16'(add_val), 16'd0);
        chk("rst_sub_val", 16'(sub_val), 16'd0);
        chk("rst_add_irdy", 16'(add_irdy), 16'd0);
        chk("rst_sub_irdy", 16'(sub_irdy), 16'd0);
        chk("rst_add_dat", 16'(add_dat), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_irdy", {14'd0, add_irdy, sub_irdy}, 16'h0003);

        for (int i = 0; i < 6; i++) begin
            op(tbl[i].is_sub, tbl[i].a, tbl[i].b, tbl[i].ctl);
            recv($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].ctl, 1'b0, 0);
        end

        // Backpressure, then a following operation.
        op(1'b0, 16'h0005, 16'h0007, 8'h22);
        recv("stall", 16'h000C, 8'h22, 1'b0, 5);
        op(1'b0, 16'h0100, 16'h0200, 8'h23);
        recv("after_stall", 16'h0300, 8'h23, 1'b0, 0);

        // A second sop discards the first partial operation.
        sel = 1'b0;
        send(8'h11, 8'h22, 1'b1, 1'b0, 8'h33);
        chk("sopsop_no_out", 16'(add_val), 16'd0);
        op(1'b0, 16'h0040, 16'h0002, 8'h44);
        recv("sopsop", 16'h0042, 8'h44, 1'b0, 0);

        // Short operation: one beat with sop+eop, upper word reads 0, err set.
        sel = 1'b0;
        send(8'h05, 8'h07, 1'b1, 1'b1, 8'h55);
        recv("short", 16'h000C, 8'h55, 1'b1, 0);

        // Reset during DRAIN drops the result.
        op(1'b1, 16'h0003, 16'h0005, 8'h66);
        o_rdy = 1'b0;
        chk("drain_val", 16'(sub_val), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("drain_rst_val", 16'(sub_val), 16'd0);
        rst = 1'b0; o_rdy = 1'b1;
        @(negedge clk);
        op(1'b1, 16'h1234, 16'h0034, 8'h77);
        recv("post_drain_rst", 16'h1200, 8'h77, 1'b0, 0);

        // Out-of-range operand: data still reduced, err only with the range check.
`ifdef EC_FPN_ADDSUB_RANGE_CHK_EN
        exp_rng = 1'b1;
`else
        exp_rng = 1'b0;
`endif
        op(1'b0, 16'hFFF5, 16'h0001, 8'h88);
        recv("range", 16'h0005, 8'h88, exp_rng, 0);

        for (int i = 0; i < 40; i++) begin
            rs   = 1'($urandom_range(0, 1));
            ra   = 16'($urandom_range(0, 32'hFFF0));
            rb   = 16'($urandom_range(0, 32'hFFF0));
            rexp = ref_model(rs, ra, rb);
            op(rs, ra, rb, 8'(i));
            recv($sformatf("rnd%0d_%s_%h_%h", i, rs ? "sub" : "add", ra, rb), rexp, 8'(i), 1'b0,
                 int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
